// File: rtl/esc_frame_sched_if.sv
// rtl/esc_frame_sched_if.sv - command and ESC-update bundle for esc_frame_sched
//
// Purpose: groups the flight-controller command handshake and the shared
// ESC update bus into one interface.
//   cmd_vld / cmd_rdy              : command handshake
//   frnt/bck/lft/rght_cmd [10:0]   : commanded motor speeds
//   frnt/bck/lft/rght_spd [10:0]   : speeds presented to the ESC generators
//   wrt                            : one-cycle update strobe for all four ESCs
//   armed                          : scheduler is in RUN
// master = flight-controller side, slave = scheduler side.

interface esc_frame_sched_if;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [10:0] frnt_cmd;
  logic [10:0] bck_cmd;
  logic [10:0] lft_cmd;
  logic [10:0] rght_cmd;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        wrt;
  logic        armed;

  modport master (
    output cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  cmd_rdy, frnt_spd, bck_spd, lft_spd, rght_spd, wrt, armed
  );

  modport slave (
    input  cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output cmd_rdy, frnt_spd, bck_spd, lft_spd, rght_spd, wrt, armed
  );
endinterface

// File: rtl/esc_frame_sched.sv
// rtl/esc_frame_sched.sv - frame-synchronous speed scheduler for four ESC generators
//
// Purpose: arms the motors with a run of zero-speed frames, then accepts
// speed commands, clamps them to [IDLE_SPD, MAX_SPD] and hands one coherent
// update to all four ESC generators per FRAME_CLKS-cycle frame.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   kill   : synchronous level-sensitive emergency stop
//   bus    : esc_frame_sched_if.slave (command handshake, speeds, wrt, armed)
// Build option: define SLEW_LIMIT_EN to limit each motor's per-frame
// speed increase to SLEW_STEP (decreases still apply immediately).

module esc_frame_sched #(
  parameter int          FRAME_CLKS = 25000,
  parameter int          ARM_FRAMES = 64,
  parameter logic [10:0] IDLE_SPD   = 11'd80,
  parameter logic [10:0] MAX_SPD    = 11'd2000
`ifdef SLEW_LIMIT_EN
  , parameter logic [10:0] SLEW_STEP = 11'd32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  esc_frame_sched_if.slave  bus
);

  localparam int               CNT_W    = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int               ARM_W    = $clog2(ARM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_FRAMES);
  localparam logic [11:0]      IDLE_12  = {1'b0, IDLE_SPD};
  localparam logic [11:0]      MAX_12   = {1'b0, MAX_SPD};

  typedef enum logic {
    ST_ARMING = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [3:0][10:0]  tgt_q, tgt_d;
  logic [3:0][10:0]  spd_q, spd_d;
  logic              wrt_q, wrt_d;
  logic [3:0][10:0]  cmd_in;
  logic              frame_tick;
  logic              cmd_acc;
  logic              cmd_rdy;
  logic              armed;

  // Motor index order: 0 = front, 1 = back, 2 = left, 3 = right.
  assign cmd_in     = {bus.rght_cmd, bus.lft_cmd, bus.bck_cmd, bus.frnt_cmd};
  assign frame_tick = (frame_cnt_q == CNT_LAST);
  assign cmd_acc    = bus.cmd_vld && cmd_rdy;

  function automatic logic [11:0] clamp12(input logic [10:0] tgt);
    logic [11:0] t;
    t = {1'b0, tgt};
    if (t < IDLE_12) begin
      t = IDLE_12;
    end else if (t > MAX_12) begin
      t = MAX_12;
    end
    return t;
  endfunction

`ifdef SLEW_LIMIT_EN
  // 12-bit add so cur + SLEW_STEP cannot wrap before the comparison.
  function automatic logic [11:0] slew12(input logic [11:0] t, input logic [10:0] cur);
    logic [11:0] lim;
    lim = {1'b0, cur} + {1'b0, SLEW_STEP};
    return (t > lim) ? lim : t;
  endfunction
`endif

  function automatic logic [10:0] sat11(input logic [11:0] v);
    return (v > MAX_12) ? MAX_SPD : v[10:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARMING;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill overrides everything, from any state.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_ARMING;
    end else begin
      case (state_q)
        ST_ARMING: if (arm_cnt_q == ARM_DONE) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_ARMING;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    cmd_rdy = 1'b0;
    armed   = 1'b0;
    if (state_q == ST_RUN) begin
      cmd_rdy = 1'b1;
      armed   = 1'b1;
    end
  end

  // Datapath: the frame counter free-runs and is untouched by kill, so the
  // wrt spacing is fixed no matter what the command side does.
  always_comb begin
    frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;

    arm_cnt_d = arm_cnt_q;
    if (kill) begin
      arm_cnt_d = '0;
    end else if ((state_q == ST_ARMING) && frame_tick && (arm_cnt_q != ARM_DONE)) begin
      arm_cnt_d = arm_cnt_q + 1'b1;
    end

    tgt_d = tgt_q;
    if (kill) begin
      tgt_d = '0;
    end else if (cmd_acc) begin
      tgt_d = cmd_in;
    end

    // Emission samples tgt_q, so a command taken on the tick cycle itself
    // lands one frame later. A kill on the tick still fires wrt, with zeros.
    wrt_d = frame_tick;
    spd_d = spd_q;
    if (frame_tick) begin
      if (kill || (state_q != ST_RUN)) begin
        spd_d = '0;
      end else begin
        for (int m = 0; m < 4; m++) begin
`ifdef SLEW_LIMIT_EN
          spd_d[m] = sat11(slew12(clamp12(tgt_q[m]), spd_q[m]));
`else
          spd_d[m] = sat11(clamp12(tgt_q[m]));
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      arm_cnt_q   <= '0;
      tgt_q       <= '0;
      spd_q       <= '0;
      wrt_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      arm_cnt_q   <= arm_cnt_d;
      tgt_q       <= tgt_d;
      spd_q       <= spd_d;
      wrt_q       <= wrt_d;
    end
  end

  assign bus.frnt_spd = spd_q[0];
  assign bus.bck_spd  = spd_q[1];
  assign bus.lft_spd  = spd_q[2];
  assign bus.rght_spd = spd_q[3];
  assign bus.wrt      = wrt_q;
  assign bus.cmd_rdy  = cmd_rdy;
  assign bus.armed    = armed;

endmodule

// File: tb/tb_esc_frame_sched.sv
// tb/tb_esc_frame_sched.sv - self-checking bench for esc_frame_sched

module tb_esc_frame_sched;

  localparam int F    = 64;
  localparam int A    = 4;
  localparam int IDLE = 80;
  localparam int MAXS = 2000;
`ifdef SLEW_LIMIT_EN
  localparam int SLEW     = 32;
  localparam int N_TO_1000 = 32;
`else
  localparam int N_TO_1000 = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kill = 1'b0;

  always #5 clk = ~clk;

  esc_frame_sched_if bus();

  esc_frame_sched #(
    .FRAME_CLKS(F),
    .ARM_FRAMES(A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wrt = -1;
  logic [10:0] prev[4];
  int cur[4];
  int tgt[4];

  function automatic logic [10:0] spd(input int i);
    logic [10:0] v;
    case (i)
      0:       v = bus.frnt_spd;
      1:       v = bus.bck_spd;
      2:       v = bus.lft_spd;
      default: v = bus.rght_spd;
    endcase
    return v;
  endfunction

  function automatic int clampm(input int t);
    if (t < IDLE) return IDLE;
    if (t > MAXS) return MAXS;
    return t;
  endfunction

  function automatic int shapem(input int t, input int c);
    int v;
    v = clampm(t);
`ifdef SLEW_LIMIT_EN
    if (v > c + SLEW) v = c + SLEW;
`endif
    if (c < 0) v = 0;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; checks wrt spacing and that speeds move only on wrt.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wrt) begin
      if (last_wrt >= 0) chk("wrt_spacing", cyc - last_wrt, F);
      last_wrt = cyc;
    end else begin
      for (int i = 0; i < 4; i++) chk("spd_hold", spd(i), prev[i]);
    end
    for (int i = 0; i < 4; i++) prev[i] = spd(i);
  endtask

  task automatic next_wrt();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.wrt && n < F + 2);
    if (!bus.wrt) chk("wrt_timeout", bus.wrt, 1);
  endtask

  task automatic expect_spd(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, spd(i), cur[i]);
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 4; i++) cur[i] = shapem(tgt[i], cur[i]);
    next_wrt();
    expect_spd(tag);
    chk({tag, "_armed"}, bus.armed, 1);
  endtask

  task automatic settle(input string tag, output int nfr);
    bit done;
    done = 1'b0;
    nfr = 0;
    while (!done && nfr < 80) begin
      run_frame(tag);
      nfr++;
      done = 1'b1;
      for (int i = 0; i < 4; i++) if (cur[i] != clampm(tgt[i])) done = 1'b0;
    end
    chk({tag, "_settled"}, done, 1);
  endtask

  task automatic arm_sequence(input string tag, input bit first);
    for (int i = 0; i < 4; i++) begin
      cur[i] = 0;
      tgt[i] = 0;
    end
    for (int k = 0; k < A; k++) begin
      next_wrt();
      if (first && k == 0) chk("first_wrt_cycle", cyc, F);
      expect_spd({tag, "_zero"});
      chk({tag, "_armed_low"}, bus.armed, 0);
      chk({tag, "_rdy_low"}, bus.cmd_rdy, 0);
    end
    step();
    chk({tag, "_armed_rise"}, bus.armed, 1);
    chk({tag, "_rdy_rise"}, bus.cmd_rdy, 1);
  endtask

  task automatic issue_now(input int f, input int b, input int l, input int r);
    bus.frnt_cmd = 11'(f);
    bus.bck_cmd  = 11'(b);
    bus.lft_cmd  = 11'(l);
    bus.rght_cmd = 11'(r);
    bus.cmd_vld  = 1'b1;
    step();
    bus.cmd_vld  = 1'b0;
    bus.frnt_cmd = 11'($urandom_range(0, 2047));
    bus.bck_cmd  = 11'($urandom_range(0, 2047));
    bus.lft_cmd  = 11'($urandom_range(0, 2047));
    bus.rght_cmd = 11'($urandom_range(0, 2047));
    tgt[0] = f;
    tgt[1] = b;
    tgt[2] = l;
    tgt[3] = r;
  endtask

  task automatic issue(input int f, input int b, input int l, input int r);
    repeat ($urandom_range(1, F / 2)) step();
    issue_now(f, b, l, r);
  endtask

  initial begin
    int nfr;
    bus.cmd_vld  = 1'b0;
    bus.frnt_cmd = '0;
    bus.bck_cmd  = '0;
    bus.lft_cmd  = '0;
    bus.rght_cmd = '0;
    for (int i = 0; i < 4; i++) prev[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("reset_spd", spd(i), 0);
    chk("reset_wrt", bus.wrt, 0);
    chk("reset_rdy", bus.cmd_rdy, 0);
    chk("reset_armed", bus.armed, 0);
    rst_n = 1'b1;
    cyc = 0;

    arm_sequence("arm0", 1'b1);

    issue(1000, 1000, 1000, 1000);
    settle("cmd1000", nfr);
    chk("frames_to_1000", nfr, N_TO_1000);

    issue(20, 2047, 80, 2000);
    settle("clamp", nfr);

    for (int k = 0; k < 6; k++) begin
      issue($urandom_range(0, 2047), $urandom_range(0, 2047),
            $urandom_range(0, 2047), $urandom_range(0, 2047));
      settle("rand", nfr);
    end

    repeat (5) step();
    issue_now(500, 500, 500, 500);
    repeat (3) step();
    issue_now(700, 700, 700, 700);
    settle("last_wins", nfr);

    // Command accepted on the tick cycle: this wrt keeps the old targets.
    repeat (F - 1) step();
    bus.frnt_cmd = 11'd900;
    bus.bck_cmd  = 11'd1100;
    bus.lft_cmd  = 11'd300;
    bus.rght_cmd = 11'd1700;
    bus.cmd_vld  = 1'b1;
    step();
    bus.cmd_vld  = 1'b0;
    chk("tick_cmd_wrt", bus.wrt, 1);
    for (int i = 0; i < 4; i++) cur[i] = shapem(tgt[i], cur[i]);
    expect_spd("tick_cmd_old");
    tgt[0] = 900;
    tgt[1] = 1100;
    tgt[2] = 300;
    tgt[3] = 1700;
    settle("tick_cmd_new", nfr);

    // Mid-frame kill pulse from 1500.
    issue(1500, 1500, 1500, 1500);
    settle("pre_kill", nfr);
    repeat (10) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_armed", bus.armed, 0);
    chk("kill_rdy", bus.cmd_rdy, 0);
    arm_sequence("rearm1", 1'b0);

    issue(1000, 1200, 64, 2047);
    settle("post_kill", nfr);

    // Kill held across two frames.
    kill = 1'b1;
    step();
    for (int i = 0; i < 4; i++) cur[i] = 0;
    for (int k = 0; k < 2; k++) begin
      next_wrt();
      expect_spd("kill_hold_zero");
      chk("kill_hold_armed", bus.armed, 0);
    end
    repeat (5) step();
    kill = 1'b0;
    arm_sequence("rearm2", 1'b0);

    // Kill on the tick cycle: wrt still fires, carrying zeros.
    issue($urandom_range(100, 2000), $urandom_range(100, 2000),
          $urandom_range(100, 2000), $urandom_range(100, 2000));
    settle("pre_tick_kill", nfr);
    repeat (F - 1 - (cyc - last_wrt)) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("tick_kill_wrt", bus.wrt, 1);
    for (int i = 0; i < 4; i++) cur[i] = 0;
    expect_spd("tick_kill_zero");
    arm_sequence("rearm3", 1'b0);

    issue(1000, 1000, 1000, 1000);
    settle("final", nfr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
